// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one left/right shift datapath between two requesters.
// The result is registered once and delivered on a single valid/ready stream tagged with the requester ID.

module shift_left #(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input  logic [N-1:0]  din,
  input  logic [SW-1:0] shift_n,
  output logic [N-1:0]  dout
);
  // Amounts of N or more flush every bit out.
  assign dout = (shift_n >= SW'(N)) ? '0 : (din << shift_n);
endmodule

module shift_right #(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input  logic [N-1:0]  din,
  input  logic [SW-1:0] shift_n,
  output logic [N-1:0]  dout
);
  assign dout = (shift_n >= SW'(N)) ? '0 : (din >> shift_n);
endmodule

module shift_arbiter #(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_din,
  input  logic [SW-1:0] req0_shift,
  input  logic          req0_left,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_din,
  input  logic [SW-1:0] req1_shift,
  input  logic          req1_left,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_id,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Ready is only offered to the granted requester and only when the output register can load.
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]    state;
  logic          last_grant;
  logic          grant_valid;
  logic          grant_id;
  logic          can_load;
  logic          accept;
  logic [N-1:0]  sel_din;
  logic [SW-1:0] sel_shift;
  logic          sel_left;
  logic [N-1:0]  shl_out;
  logic [N-1:0]  shr_out;
  logic [N-1:0]  shifted;

  assign out_valid   = (state == FULL);
  assign can_load    = !out_valid || out_ready;
  assign grant_valid = req0_valid || req1_valid;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign accept     = grant_valid && can_load;
  assign req0_ready = grant_valid && !grant_id && can_load;
  assign req1_ready = grant_valid &&  grant_id && can_load;

  assign sel_din   = grant_id ? req1_din   : req0_din;
  assign sel_shift = grant_id ? req1_shift : req0_shift;
  assign sel_left  = grant_id ? req1_left  : req0_left;

  shift_left  #(.N(N), .SW(SW)) u_shl (.din(sel_din), .shift_n(sel_shift), .dout(shl_out));
  shift_right #(.N(N), .SW(SW)) u_shr (.din(sel_din), .shift_n(sel_shift), .dout(shr_out));

  assign shifted = sel_left ? shl_out : shr_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_id     <= 1'b0;
      last_grant <= 1'b1;
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else if (accept) begin
      state      <= FULL;
      out_data   <= shifted;
      out_id     <= grant_id;
      last_grant <= grant_id;
      if (!grant_id && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if ( grant_id && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised and directed bench for shift_arbiter with a queue scoreboard
// and an arithmetic reference model of arbitration and shifting.

module tb_shift_arbiter;
  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [N-1:0]  req0_din = '0, req1_din = '0;
  logic [SW-1:0] req0_shift = '0, req1_shift = '0;
  logic          req0_left = 1'b0, req1_left = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_data;
  logic          out_id;
  logic [15:0]   grant_cnt0, grant_cnt1;

  shift_arbiter #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
    .req0_shift(req0_shift), .req0_left(req0_left),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
    .req1_shift(req1_shift), .req1_left(req1_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state and reference model
  logic [N:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       model_full = 1'b0;
  logic       model_last = 1'b1;
  int         model_cnt0 = 0;
  int         model_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] din, input int sh, input logic left);
    int unsigned v;
    v = din;
    if (left) v = (v << sh) % 256;
    else      v = v >> sh;
    return v[N-1:0];
  endfunction

  // One bus cycle: inputs already driven just after the previous rising edge.
  task automatic step();
    logic gv, gid, can, acc;
    logic [N-1:0] d;
    @(negedge clk);
    gv  = req0_valid || req1_valid;
    gid = (req0_valid && req1_valid) ? ~model_last : req1_valid;
    can = !model_full || out_ready;
    acc = gv && can;
    check("req0_ready", req0_ready, acc && !gid);
    check("req1_ready", req1_ready, acc &&  gid);
    @(posedge clk);
    if (acc) begin
      d = gid ? ref_shift(req1_din, req1_shift, req1_left) : ref_shift(req0_din, req0_shift, req0_left);
      exp_q.push_back({gid, d});
      model_last = gid;
      model_full = 1'b1;
      if (!gid) model_cnt0 = (model_cnt0 < 65535) ? model_cnt0 + 1 : 65535;
      else      model_cnt1 = (model_cnt1 < 65535) ? model_cnt1 + 1 : 65535;
    end else if (out_ready) begin
      model_full = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic v0, input logic [N-1:0] d0, input logic [SW-1:0] s0, input logic l0,
                       input logic v1, input logic [N-1:0] d1, input logic [SW-1:0] s1, input logic l1,
                       input logic ordy);
    req0_valid = v0; req0_din = d0; req0_shift = s0; req0_left = l0;
    req1_valid = v1; req1_din = d1; req1_shift = s1; req1_left = l1;
    out_ready  = ordy;
    step();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_id", out_id, 1'b0);
    check("rst_cnt0", grant_cnt0, 16'd0);
    check("rst_cnt1", grant_cnt1, 16'd0);
    exp_q.delete();
    model_full = 1'b0; model_last = 1'b1; model_cnt0 = 0; model_cnt1 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, model_full);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1'b1, 1'b0);
        end else begin
          check("out_data", out_data, exp_q[0][N-1:0]);
          check("out_id", out_id, exp_q[0][N]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N-1:0] bd[7];
    int           bs[7];
    logic         bl[7];
    @(posedge clk); #1;
    do_reset();

    // single request, both directions
    drive(1'b1, 8'b1011_0001, 4'd3, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    check("single_left", out_data, 8'b1000_1000);
    drive(1'b1, 8'b1011_0001, 4'd3, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    check("single_right", out_data, 8'b0001_0110);

    // mid-run reset, then fairness
    drive(1'b1, 8'h3C, 4'd1, 1'b1, 1'b1, 8'hC3, 4'd2, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, N'($urandom_range(0, 255)), SW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'b1, N'($urandom_range(0, 255)), SW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    idle(1'b1);
    check("fair_cnt0", grant_cnt0, 16'd4);
    check("fair_cnt1", grant_cnt1, 16'd4);

    // backpressure: fill, stall 3 cycles with req1 pending, then release
    drive(1'b1, 8'hA5, 4'd2, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 8'h96, 4'd1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 8'h96, 4'd1, 1'b0, 1'b1);
    idle(1'b1);
    check("bp_release", out_data, 8'h4B);
    idle(1'b1);

    // boundaries through req0
    bd = '{8'h5A, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bs = '{0, 7, 8, 8, 15, 15, 7};
    bl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) drive(1'b1, bd[i], SW'(bs[i]), bl[i], 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    check("bnd_last", out_data, 8'h01);

    // exhaustive through req1
    for (int d = 0; d < 256; d++)
      for (int s = 0; s < 16; s++)
        for (int l = 0; l < 2; l++)
          drive(1'b0, '0, '0, 1'b0, 1'b1, N'(d), SW'(s), 1'(l), 1'b1);

    // random traffic with random backpressure
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 1)), N'($urandom_range(0, 255)), SW'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom_range(0, 255)),
            SW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

    idle(1'b1);
    idle(1'b1);
    check("final_cnt0", grant_cnt0, 16'(model_cnt0));
    check("final_cnt1", grant_cnt1, 16'(model_cnt1));
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
